// File: rtl/mant_div_pkg.sv
// Shared types and constants for the iterative mantissa divider.
package mant_div_pkg;

  localparam int MANT_W = 24;
  localparam int CNT_W  = $clog2(MANT_W + 1);

  localparam logic [MANT_W:0] QUOT_ONES = {(MANT_W + 1){1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/single_div.sv
// One restoring-division stage: compare, conditionally subtract, shift left.
module single_div #(
  parameter int W = 25
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         q_bit,
  output logic [W-1:0] r_next
);

  logic [W-1:0] diff;

  assign q_bit  = (a >= b);
  assign diff   = a - b;
  assign r_next = q_bit ? {diff[W-2:0], 1'b0} : {a[W-2:0], 1'b0};

endmodule

// File: rtl/mantissa_div_seq.sv
// Iterative mantissa divider: one restoring stage reused over MANT_W+1 cycles.
module mantissa_div_seq
  import mant_div_pkg::*;
#(
  parameter int MANT_W     = 24,
  parameter bit EARLY_TERM = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] dividend,
  input  logic [MANT_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W:0]   quotient,
  output logic [MANT_W:0]   residue,
  output logic              sticky,
  output logic              div_by_zero
);

  localparam int QW     = MANT_W + 1;
  localparam int CNT_LW = $clog2(MANT_W + 1);
  localparam logic [CNT_LW-1:0] LAST_STEP = CNT_LW'(MANT_W);

  state_e state_q, state_d;

  logic [MANT_W-1:0] dsr_q, dsr_d;
  logic [QW-1:0]     res_q, res_d;
  logic [QW-1:0]     quot_q, quot_d;
  logic [CNT_LW-1:0] cnt_q, cnt_d;
  logic              dbz_q, dbz_d;

  logic              stage_bit;
  logic [QW-1:0]     stage_res;

  // Once the residue is zero every remaining step yields a 0 bit, so the
  // partial quotient only needs to be moved up to its final weight.
  function automatic logic [QW-1:0] early_align(input logic [QW-1:0]     q,
                                                input logic [CNT_LW-1:0] step);
    return q << (LAST_STEP - step);
  endfunction

  function automatic logic or_reduce(input logic [QW-1:0] v);
    return |v;
  endfunction

  single_div #(
    .W (QW)
  ) u_stage (
    .a      (res_q),
    .b      ({1'b0, dsr_q}),
    .q_bit  (stage_bit),
    .r_next (stage_res)
  );

  always_comb begin
    state_d = state_q;
    dsr_d   = dsr_q;
    res_d   = res_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dsr_d   = divisor;
          res_d   = {1'b0, dividend};
          quot_d  = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // A zero divisor spends its single RUN cycle producing the saturated result.
        if (dsr_q == '0) begin
          quot_d  = '1;
          res_d   = '0;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          quot_d = {quot_q[QW-2:0], stage_bit};
          res_d  = stage_res;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_d = DONE;
          end else if (EARLY_TERM && (stage_res == '0)) begin
            quot_d  = early_align({quot_q[QW-2:0], stage_bit}, cnt_q);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dsr_q   <= '0;
      res_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dsr_q   <= dsr_d;
      res_q   <= res_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign residue     = res_q;
  assign sticky      = or_reduce(res_q);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mantissa_div_seq.sv
// Directed and random bench for mantissa_div_seq, full-run and early-exit builds.
module tb_mantissa_div_seq;
  import mant_div_pkg::*;

  localparam int W = 24;

  typedef struct packed {
    logic [W:0] q;
    logic [W:0] r;
    logic       dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         use_et = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;

  logic         iv_a, iv_b, or_a, or_b;
  logic         ir_a, ir_b, ov_a, ov_b, st_a, st_b, dz_a, dz_b;
  logic [W:0]   q_a, q_b, r_a, r_b;

  assign iv_a = in_valid & ~use_et;
  assign iv_b = in_valid & use_et;
  assign or_a = out_ready & ~use_et;
  assign or_b = out_ready & use_et;

  logic       ir_m, ov_m, st_m, dz_m;
  logic [W:0] q_m, r_m;
  assign ir_m = use_et ? ir_b : ir_a;
  assign ov_m = use_et ? ov_b : ov_a;
  assign st_m = use_et ? st_b : st_a;
  assign dz_m = use_et ? dz_b : dz_a;
  assign q_m  = use_et ? q_b  : q_a;
  assign r_m  = use_et ? r_b  : r_a;

  mantissa_div_seq #(.MANT_W(W), .EARLY_TERM(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a),
    .dividend(dividend), .divisor(divisor), .out_valid(ov_a), .out_ready(or_a),
    .quotient(q_a), .residue(r_a), .sticky(st_a), .div_by_zero(dz_a)
  );

  mantissa_div_seq #(.MANT_W(W), .EARLY_TERM(1'b1)) dut_et (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b),
    .dividend(dividend), .divisor(divisor), .out_valid(ov_b), .out_ready(or_b),
    .quotient(q_b), .residue(r_b), .sticky(st_b), .div_by_zero(dz_b)
  );

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] num;
    logic [63:0] den;
    if (b == '0) begin
      e.q   = QUOT_ONES;
      e.r   = '0;
      e.dbz = 1'b1;
    end else begin
      num   = {16'd0, a, 24'd0};
      den   = {40'd0, b};
      e.q   = (W+1)'(num / den);
      e.r   = (W+1)'((num % den) << 1);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // exp_lat < 0 skips the latency check; hold = cycles of out_ready low in DONE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int exp_lat, input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk("in_ready_idle", 64'(ir_m), 64'(1));
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = 0;
    while (!ov_m && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    if (!ov_m) begin
      chk("out_valid_timeout", 64'(ov_m), 64'(1));
      return;
    end
    if (exp_lat >= 0) chk("latency", 64'(lat), 64'(exp_lat));
    chk("quotient", 64'(q_m), 64'(e.q));
    chk("residue", 64'(r_m), 64'(e.r));
    chk("sticky", 64'(st_m), 64'(e.r != '0));
    chk("div_by_zero", 64'(dz_m), 64'(e.dbz));
    chk("in_ready_busy", 64'(ir_m), 64'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(ov_m), 64'(1));
      chk("hold_quotient", 64'(q_m), 64'(e.q));
      chk("hold_residue", 64'(r_m), 64'(e.r));
      chk("hold_in_ready", 64'(ir_m), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_hs", 64'(ir_m), 64'(1));
    chk("out_valid_after_hs", 64'(ov_m), 64'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb;

    // Reset state, held across a couple of edges
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(ir_a), 64'(1));
    chk("rst_out_valid", 64'(ov_a), 64'(0));
    chk("rst_quotient", 64'(q_a), 64'(0));
    chk("rst_residue", 64'(r_a), 64'(0));
    chk("rst_sticky", 64'(st_a), 64'(0));
    chk("rst_dbz", 64'(dz_a), 64'(0));
    rst_n = 1'b1;

    // Full-run directed operands
    do_op(24'h800000, 24'h800000, 25, 0);
    do_op(24'hC00000, 24'h800000, 25, 0);
    do_op(24'h800000, 24'hC00000, 25, 0);
    do_op(24'hFFFFFF, 24'h800000, 25, 0);
    do_op(24'h800000, 24'hFFFFFF, 25, 0);
    do_op(24'h9ABCDE, 24'h000000, 1, 0);
    do_op(24'hC00000, 24'hA00000, 25, 10);

    // Reset in the middle of RUN
    @(negedge clk);
    dividend = 24'h800000;
    divisor  = 24'hC00000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(ir_a), 64'(1));
    chk("midrst_out_valid", 64'(ov_a), 64'(0));
    chk("midrst_quotient", 64'(q_a), 64'(0));
    chk("midrst_residue", 64'(r_a), 64'(0));
    chk("midrst_sticky", 64'(st_a), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("midrst_no_result", 64'(ov_a), 64'(0));
    do_op(24'hC00000, 24'h800000, 25, 0);

    // Early-exit build
    use_et = 1'b1;
    do_op(24'h800000, 24'h800000, 1, 0);
    do_op(24'hC00000, 24'h800000, 2, 0);
    do_op(24'h800000, 24'hC00000, 25, 0);
    do_op(24'hA00000, 24'h000000, 1, 0);
    do_op(24'hA00000, 24'h800000, 3, 2);

    // Random regression on both builds
    use_et = 1'b0;
    for (int n = 0; n < 150; n++) begin
      ra = 24'h800000 | W'($urandom_range(0, 24'h7FFFFF));
      rb = 24'h800000 | W'($urandom_range(0, 24'h7FFFFF));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(ra, rb, 25, int'($urandom_range(0, 3)));
    end
    use_et = 1'b1;
    for (int n = 0; n < 100; n++) begin
      ra = 24'h800000 | W'($urandom_range(0, 24'h7FFFFF));
      rb = (n % 4 == 0) ? ra : (24'h800000 | W'($urandom_range(0, 24'h7FFFFF)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(ra, rb, -1, int'($urandom_range(0, 3)));
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
